// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DSIZE = 8;
  localparam int unsigned DEFAULT_ASIZE = 4;
  localparam int unsigned DEFAULT_DEPTH = 1 << DEFAULT_ASIZE;

  // Occupancy type for the default geometry (0..DEPTH needs one extra bit).
  typedef logic [DEFAULT_ASIZE:0] count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port storage for sync_fifo: synchronous write, combinational read, no reset.
module sync_fifo_mem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  logic [DSIZE-1:0] r_mem [1 << ASIZE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = DEFAULT_DSIZE,
  parameter int unsigned ASIZE    = DEFAULT_ASIZE,
  parameter int unsigned AF_LEVEL = (1 << ASIZE) - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] FULL_CNT = (ASIZE + 1)'(1 << ASIZE);
  localparam logic [ASIZE:0] AF_CNT   = (ASIZE + 1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_CNT   = (ASIZE + 1)'(AE_LEVEL);

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [DSIZE-1:0] w_mem_rdata;

  // Pointers carry one wrap bit, so their modular difference spans 0..DEPTH.
  assign count        = r_wptr - r_rptr;
  assign rempty       = (count == '0);
  assign wfull        = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_en = winc & ~wfull;
  assign w_rd_en = rinc & ~rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      if (winc && wfull)  r_overflow  <= 1'b1;
      if (rinc && rempty) r_underflow <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = rempty ? '0 : w_mem_rdata;
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= w_mem_rdata;
    end
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth = 2^ASIZE words.
REQ-003 SHALL have parameter AF_LEVEL, default 2^ASIZE-2, almost-full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port winc, input, 1, write request.
REQ-008 SHALL have port wdata, input, DSIZE, write data.
REQ-009 SHALL have port rinc, input, 1, read request.
REQ-010 SHALL have port rdata, output, DSIZE, read data.
REQ-011 SHALL have ports wfull and rempty, output, 1 each, full and empty flags.
REQ-012 SHALL have ports almost_full and almost_empty, output, 1 each, threshold flags.
REQ-013 SHALL have port count, output, ASIZE+1, number of stored words (0..2^ASIZE).
REQ-014 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-015 SHALL accept a write on an edge where winc=1 and wfull=0, storing wdata at the write pointer.
REQ-016 SHALL accept a read on an edge where rinc=1 and rempty=0, advancing the read pointer.
REQ-017 SHALL keep read and write pointers ASIZE+1 bits wide, wrapping modulo 2^(ASIZE+1); the low ASIZE bits address memory.
REQ-018 SHALL derive rempty = (count==0), wfull = (count==2^ASIZE), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-019 SHALL update count +1 on write only, -1 on read only, and leave it unchanged on simultaneous accepted read and write.
REQ-020 SHALL reject winc while wfull=1, even with a same-cycle accepted read; memory and write pointer unchanged.
REQ-021 SHALL reject rinc while rempty=1, even with a same-cycle accepted write; rdata and read pointer unchanged.
REQ-022 SHALL set overflow on any edge with winc=1 and wfull=1, and underflow on any edge with rinc=1 and rempty=1; both hold until reset.
REQ-023 SHALL reflect flags and count one cycle after the accepted transfer edge; a write into an empty FIFO deasserts rempty on the following cycle.
REQ-024 SHALL preserve strict first-in first-out ordering across pointer wrap-around.

Reset
REQ-025 SHALL, while rst_n=0, force pointers and count to 0, rempty=1, almost_empty=1, wfull=0, almost_full=0, overflow=0, underflow=0, rdata=0.
REQ-026 SHALL discard all stored words on reset asserted mid-operation; memory contents SHALL NOT be reset.
REQ-027 SHALL ignore winc and rinc on the first rising clk edge after rst_n deasserts only if that deassertion is less than one setup time before it; otherwise operate normally.

Configuration
REQ-028 SHALL compile first-word-fall-through mode when macro SYNC_FIFO_FWFT_EN is defined: rdata continuously shows the head word whenever rempty=0, and rinc pops it.
REQ-029 SHALL, without SYNC_FIFO_FWFT_EN, register rdata: the popped word appears on rdata one cycle after the accepted-read edge and holds until the next accepted read.

Structure
REQ-030 SHALL place shared constants (default DSIZE/ASIZE, derived DEPTH) and the count type in package sync_fifo_pkg.
REQ-031 SHALL instantiate one sub-module sync_fifo_mem: 2^ASIZE x DSIZE dual-port memory, synchronous write, combinational read.

Verification
REQ-032 Reset, then idle -> rempty=1, almost_empty=1, wfull=0, count=0, rdata=0.
REQ-033 Write 16 words 0x01..0x10 (DSIZE=8, ASIZE=4) -> count reaches 16, almost_full at count=14, wfull at 16; read 16 -> 0x01..0x10 in order, rempty=1.
REQ-034 Full FIFO, winc=1 and rinc=1 same cycle -> write rejected, count=15, overflow=1.
REQ-035 Empty FIFO, rinc=1 -> underflow=1, count=0; winc=1 and rinc=1 same cycle -> count=1, rdata unchanged.
REQ-036 Write 10, read 10, write 12, read 12 -> pointers wrap, data order correct, count back to 0.
REQ-037 Reset asserted with count=7 -> count=0, rempty=1, overflow/underflow=0 immediately, before any clk edge.
